// File: rtl/run_controller.sv
// run_controller: launches a processor run, counts RUN cycles, detects a
// self-loop halt (pc_d == pc_q repeated) or a cycle-budget timeout, and
// optionally folds the write-back bus into a rotating signature.
//
// Optional feature macro: RUN_CTRL_SIGNATURE_EN
//   defined   -> signature <= rotl1(signature) ^ busW on every RUN cycle
//   undefined -> signature is tied to 32'h0, no signature register exists
//
// Parameters: HOLD_CYCLES >= 1, MAX_CYCLES 1..65535, HALT_REPEAT 1..255.
// All outputs come straight from flops and are loaded from the next-state
// decode, so they are registered and track the state register exactly.
module run_controller #(
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_CYCLES  = 16,
  parameter int HALT_REPEAT = 2
) (
  input  logic        clk,
  input  logic        start_up_n,
  input  logic        go,
  input  logic [31:0] pc_q,
  input  logic [31:0] pc_d,
  input  logic [31:0] busW,
  output logic        start_up,
  output logic        running,
  output logic        done,
  output logic        halted,
  output logic [15:0] cycle_count,
  output logic [31:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [15:0]   MAX_C     = 16'(MAX_CYCLES);
  localparam logic [7:0]    HREP      = 8'(HALT_REPEAT);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    hrep_q, hrep_d;
  logic [15:0]   cc_d;
  logic          clr_run;   // HOLD entry: wipe run statistics
  logic          run_step;  // this edge is a RUN cycle
  logic          pc_eq;

  assign pc_eq = (pc_d == pc_q);

  // Next-state, hold/halt counters and cycle counter update
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hrep_d   = hrep_q;
    cc_d     = cycle_count;
    clr_run  = 1'b0;
    run_step = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (go) begin
          state_d = S_HOLD;
          hold_d  = '0;
          hrep_d  = '0;
          cc_d    = '0;
          clr_run = 1'b1;
        end
      end
      S_HOLD: begin
        // go is ignored here; the hold window always runs to completion
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_RUN: begin
        run_step = 1'b1;
        cc_d     = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        if (pc_eq) hrep_d = (hrep_q == 8'hFF) ? hrep_q : hrep_q + 8'd1;
        else       hrep_d = '0;
        // Halt is checked first so it wins over a simultaneous timeout
        if (hrep_d == HREP)     state_d = S_HALTED;
        else if (cc_d == MAX_C) state_d = S_TIMEOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hrep_q      <= '0;
      cycle_count <= '0;
      start_up    <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hrep_q      <= hrep_d;
      cycle_count <= cc_d;
      start_up    <= (state_d != S_RUN);
      running     <= (state_d == S_RUN);
      done        <= (state_d == S_HALTED) || (state_d == S_TIMEOUT);
      halted      <= (state_d == S_HALTED);
    end
  end

`ifdef RUN_CTRL_SIGNATURE_EN
  logic [31:0] sig_q;

  // Rotate-left-and-xor signature over the write-back bus, RUN cycles only
  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n)   sig_q <= '0;
    else if (clr_run)  sig_q <= '0;
    else if (run_step) sig_q <= {sig_q[30:0], sig_q[31]} ^ busW;
  end

  assign signature = sig_q;
`else
  logic unused_sig_inputs;
  assign unused_sig_inputs = ^{busW, clr_run, run_step};
  assign signature         = 32'h0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller (default parameters). Stimulus pushes
// the expected output snapshot after each edge; a negedge monitor pops and
// compares. Signature expectations follow RUN_CTRL_SIGNATURE_EN.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        start_up_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] pc_q = 32'h0;
  logic [31:0] pc_d = 32'h4;
  logic [31:0] busW = 32'h0;
  logic        start_up, running, done, halted;
  logic [15:0] cycle_count;
  logic [31:0] signature;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        su, run, dn, hl;
    logic [15:0] cc;
    logic [31:0] sig;
  } exp_t;

  exp_t q[$];

  run_controller dut (
    .clk        (clk),
    .start_up_n (start_up_n),
    .go         (go),
    .pc_q       (pc_q),
    .pc_d       (pc_d),
    .busW       (busW),
    .start_up   (start_up),
    .running    (running),
    .done       (done),
    .halted     (halted),
    .cycle_count(cycle_count),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef RUN_CTRL_SIGNATURE_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic expect_st(input string n, input logic su, input logic run,
                           input logic dn, input logic hl,
                           input logic [15:0] cc, input logic [31:0] sig);
    exp_t e;
    e.name = n; e.su = su; e.run = run; e.dn = dn; e.hl = hl;
    e.cc = cc; e.sig = sig;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT outputs
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (start_up !== e.su || running !== e.run || done !== e.dn ||
          halted !== e.hl || cycle_count !== e.cc || signature !== e.sig) begin
        bad++;
        $display("FAIL %s: got su=%b run=%b done=%b halted=%b cc=%0d sig=%h, want su=%b run=%b done=%b halted=%b cc=%0d sig=%h",
                 e.name, start_up, running, done, halted, cycle_count, signature,
                 e.su, e.run, e.dn, e.hl, e.cc, e.sig);
      end
    end
  end

  task automatic launch();
    go = 1'b1;
    step();
    go = 1'b0;
    expect_st("hold1", 1, 0, 0, 0, 16'd0, 32'h0);
    step();
    expect_st("hold2", 1, 0, 0, 0, 16'd0, 32'h0);
    step();
    expect_st("run_entry", 0, 1, 0, 0, 16'd0, 32'h0);
  endtask

  logic [31:0] pcq_b [1:6];
  logic [31:0] pcd_b [1:6];
  logic [31:0] sig_c [1:3];

  initial begin
    pcq_b[1] = 32'h10;       pcd_b[1] = 32'h14;
    pcq_b[2] = 32'h14;       pcd_b[2] = 32'h18;
    pcq_b[3] = 32'h100;      pcd_b[3] = 32'h100;
    pcq_b[4] = 32'h104;      pcd_b[4] = 32'h108;
    pcq_b[5] = 32'h00400020; pcd_b[5] = 32'h00400020;
    pcq_b[6] = 32'h00400020; pcd_b[6] = 32'h00400020;
    sig_c[1] = 32'h1; sig_c[2] = 32'h3; sig_c[3] = 32'h7;

    // Reset state, then release and stay idle
    step();
    expect_st("reset", 1, 0, 0, 0, 16'd0, 32'h0);
    step();
    start_up_n = 1'b1;
    step();
    expect_st("idle", 1, 0, 0, 0, 16'd0, 32'h0);

    // A: pc always advances -> timeout after 16 RUN cycles
    launch();
    for (int k = 1; k <= 16; k++) begin
      pc_q = 32'(k * 4);
      pc_d = 32'(k * 4 + 4);
      step();
      if (k < 16) expect_st("timeout_run", 0, 1, 0, 0, 16'(k), 32'h0);
      else        expect_st("timeout", 1, 0, 1, 0, 16'd16, 32'h0);
    end
    step();
    expect_st("timeout_hold", 1, 0, 1, 0, 16'd16, 32'h0);

    // B: restart from TIMEOUT; single equal cycle ignored, go in RUN ignored,
    // two equal cycles halt at cycle 6
    launch();
    for (int k = 1; k <= 6; k++) begin
      pc_q = pcq_b[k];
      pc_d = pcd_b[k];
      go   = (k == 2);
      step();
      if (k < 6) expect_st("halt_run", 0, 1, 0, 0, 16'(k), 32'h0);
      else       expect_st("halted", 1, 0, 1, 1, 16'd6, 32'h0);
    end
    go = 1'b0;
    step();
    expect_st("halted_hold", 1, 0, 1, 1, 16'd6, 32'h0);

    // D: halt completes in the same cycle the budget runs out
    launch();
    for (int k = 1; k <= 16; k++) begin
      pc_q = 32'h2000 + 32'(k * 4);
      pc_d = (k >= 15) ? pc_q : pc_q + 32'd4;
      step();
      if (k < 16) expect_st("both_run", 0, 1, 0, 0, 16'(k), 32'h0);
      else        expect_st("halt_beats_timeout", 1, 0, 1, 1, 16'd16, 32'h0);
    end

    // C: signature over busW=1, then reset pulse in RUN cycle 3
    pc_q = 32'h0;
    pc_d = 32'h4;
    launch();
    busW = 32'h1;
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_st("sig_run", 0, 1, 0, 0, 16'(k), sx(sig_c[k]));
    end
    @(negedge clk);
    #1;
    start_up_n = 1'b0;
    #1;
    expect_st("reset_mid_run", 1, 0, 0, 0, 16'd0, 32'h0);
    step();
    start_up_n = 1'b1;
    step();
    expect_st("idle_after_abort", 1, 0, 0, 0, 16'd0, 32'h0);
    launch();
    step();
    expect_st("restart_run", 0, 1, 0, 0, 16'd1, sx(32'h1));
    busW = 32'h0;

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 5 && q.size() > 0; n++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: RUN-entry delay in cycles, during which start_up stays asserted.
REQ-002 Parameter MAX_CYCLES, default 16: RUN-cycle budget before timeout; legal range 1..65535.
REQ-003 Parameter HALT_REPEAT, default 2: consecutive pc_d==pc_q cycles that declare a self-loop halt; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 start_up_n  input  1  asynchronous, active-low reset.
REQ-006 go  input  1  launch request, sampled on clk.
REQ-007 pc_q  input  32  current PC from processor.
REQ-008 pc_d  input  32  next PC from processor.
REQ-009 busW  input  32  processor register write-back bus.
REQ-010 start_up  output  1  registered, active-high reset to processor.
REQ-011 running  output  1  high only in RUN.
REQ-012 done  output  1  high in HALTED or TIMEOUT.
REQ-013 halted  output  1  high in HALTED only; done=1,halted=0 means timeout.
REQ-014 cycle_count  output  16  RUN cycles elapsed.
REQ-015 signature  output  32  write-back signature (see Configuration).

Function
REQ-016 FSM SHALL have states IDLE, HOLD, RUN, HALTED, TIMEOUT.
REQ-017 IDLE: start_up=1; go=1 -> HOLD.
REQ-018 HOLD: start_up=1 for exactly HOLD_CYCLES cycles, then -> RUN; entry clears cycle_count, halt-repeat counter, signature.
REQ-019 RUN: start_up=0, running=1; cycle_count += 1 each RUN cycle, saturating at 16'hFFFF.
REQ-020 RUN: halt-repeat counter increments when pc_d==pc_q, clears to 0 when they differ.
REQ-021 RUN -> HALTED in the cycle the halt-repeat counter reaches HALT_REPEAT; that cycle is included in cycle_count.
REQ-022 RUN -> TIMEOUT in the cycle cycle_count reaches MAX_CYCLES.
REQ-023 Halt and timeout in the same cycle: HALTED wins.
REQ-024 HALTED/TIMEOUT: start_up=1 (processor frozen), done=1; cycle_count and signature held; go=1 -> HOLD (restart).
REQ-025 go in HOLD or RUN SHALL be ignored.
REQ-026 All outputs registered; no combinational path from any input to any output.

Reset
REQ-027 start_up_n=0 SHALL asynchronously force IDLE, start_up=1, running=0, done=0, halted=0, cycle_count=0, signature=0, halt-repeat counter=0.
REQ-028 Reset asserted in any state, including mid-RUN, SHALL abort immediately with no completion reported.
REQ-029 Release is synchronous to clk: first active edge after deassertion evaluates IDLE.

Configuration
REQ-030 Macro RUN_CTRL_SIGNATURE_EN defined: each RUN cycle signature <= {signature[30:0],signature[31]} ^ busW.
REQ-031 Macro undefined: signature port present, constant 32'h0, no signature register.

Verification
REQ-032 Reset: start_up_n=0 -> start_up=1, running=0, done=0, cycle_count=0, signature=0.
REQ-033 Defaults, 1-cycle go pulse -> start_up=1 for 2 more cycles, then start_up=0, running=1.
REQ-034 pc_d=pc_q+4 always -> after 16 RUN cycles done=1, halted=0, cycle_count=16, start_up=1.
REQ-035 pc_q=pc_d=32'h00400020 from RUN cycle 5 -> HALTED after cycle 6, halted=1, cycle_count=6; single equal cycle followed by a differing one -> no halt.
REQ-036 start_up_n pulsed low at RUN cycle 3 -> immediate IDLE, start_up=1, cycle_count=0; later go restarts normally.
REQ-037 RUN_CTRL_SIGNATURE_EN defined, busW=32'h1 for 3 RUN cycles -> signature 32'h1, 32'h3, 32'h7; undefined -> signature=0 throughout.
